// File: rtl/mem_req_driver.sv
`default_nettype none
// ==== mem_req_driver : 4-deep command FIFO feeding one outstanding mem_system request ====
// Rev 1.0 -- initial release
module mem_req_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic [15:0] Addr,
  output logic [15:0] DataIn,
  output logic        Rd,
  output logic        Wr,
  output logic        createdump,
  input  logic [15:0] DataOut,
  input  logic        Done,
  input  logic        Stall,
  input  logic        CacheHit,
  input  logic        mem_err,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_hit,
  output logic        rsp_wr,
  output logic [15:0] req_cnt,
  output logic [15:0] hit_cnt,
  output logic        err
);

  localparam int       C_DEPTH     = 4;
  localparam logic [5:0] C_WAIT_LAST = 6'd62;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_q_wr   [C_DEPTH];
  logic [15:0] r_q_addr [C_DEPTH];
  logic [15:0] r_q_data [C_DEPTH];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  logic        r_req_wr;
  logic [15:0] r_req_addr;
  logic [15:0] r_req_data;
  logic [5:0]  r_wait;
  logic [15:0] r_rsp_data;
  logic        r_rsp_hit;
  logic        r_rsp_wr;
  logic [15:0] r_req_cnt;
  logic [15:0] r_hit_cnt;

  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_capture;
  logic        w_empty;
  logic        w_head_wr;
  logic [15:0] w_head_addr;
  logic [15:0] w_head_data;
  logic        w_unused_stall;

  // Stall only reports mem_system occupancy; the request is held until Done regardless.
  assign w_unused_stall = Stall;

  assign cmd_ready   = (r_count != 3'd4);
  assign w_empty     = (r_count == 3'd0);
  assign w_push      = cmd_valid & cmd_ready;
  assign w_head_wr   = r_q_wr[r_rptr];
  assign w_head_addr = r_q_addr[r_rptr];
  assign w_head_data = r_q_data[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_wr[r_wptr]   <= cmd_wr;
      r_q_addr[r_wptr] <= cmd_addr;
      r_q_data[r_wptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          // Odd addresses are discarded without ever touching the memory port.
          if (w_head_addr[0]) begin
            w_next = S_ERR;
          end else begin
            w_load = 1'b1;
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_err) begin
          w_next = S_ERR;
        end else if (Done) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (r_wait == C_WAIT_LAST) begin
          w_next = S_ERR;
        end
      end
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_wr   <= 1'b0;
      r_req_addr <= 16'h0000;
      r_req_data <= 16'h0000;
      r_wait     <= 6'd0;
      r_rsp_data <= 16'h0000;
      r_rsp_hit  <= 1'b0;
      r_rsp_wr   <= 1'b0;
      r_req_cnt  <= 16'h0000;
      r_hit_cnt  <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_req_wr   <= w_head_wr;
        r_req_addr <= w_head_addr;
        r_req_data <= w_head_data;
        r_wait     <= 6'd0;
      end else if (r_state == S_REQ && !Done && !mem_err) begin
        r_wait <= r_wait + 6'd1;
      end
      if (w_capture) begin
        r_rsp_data <= r_req_wr ? 16'h0000 : DataOut;
        r_rsp_hit  <= CacheHit;
        r_rsp_wr   <= r_req_wr;
      end
      if (r_state == S_RESP) begin
        r_req_cnt <= r_req_cnt + 16'd1;
        if (r_rsp_hit) r_hit_cnt <= r_hit_cnt + 16'd1;
      end
    end
  end

  // Port strobes decode straight from state so an async reset drops them at once.
  assign Rd         = (r_state == S_REQ) & ~r_req_wr;
  assign Wr         = (r_state == S_REQ) &  r_req_wr;
  assign Addr       = r_req_addr;
  assign DataIn     = r_req_data;
  assign createdump = 1'b0;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_wr     = r_rsp_wr;
  assign req_cnt    = r_req_cnt;
  assign hit_cnt    = r_hit_cnt;
  assign err        = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_req_driver.sv
`default_nettype none
// Bench for mem_req_driver: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_req_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid, cmd_wr;
  logic [15:0] cmd_addr, cmd_data;
  logic        cmd_ready;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, createdump, Done, Stall, CacheHit, mem_err;
  logic        rsp_valid, rsp_hit, rsp_wr, err;
  logic [15:0] rsp_data, req_cnt, hit_cnt;

  always #5 clk = ~clk;

  mem_req_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr), .createdump(createdump),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .mem_err(mem_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_wr(rsp_wr),
    .req_cnt(req_cnt), .hit_cnt(hit_cnt), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  int rsp_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one command in service at a time, pending ones in a queue.
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef enum int {P_WAIT_CMD, P_MEM_BUSY, P_REPLY, P_FAULT} phase_e;

  phase_e      m_phase = P_WAIT_CMD;
  cmd_t        m_q[$];
  cmd_t        m_cur = '0;
  int          m_waited = 0;
  logic [15:0] m_rsp_data = '0;
  logic        m_rsp_hit = 1'b0;
  logic        m_rsp_wr = 1'b0;
  logic [15:0] m_req_cnt = '0;
  logic [15:0] m_hit_cnt = '0;

  always @(posedge clk or posedge rst) begin : model
    cmd_t head;
    bit   do_push;
    if (rst) begin
      m_phase = P_WAIT_CMD;
      m_q.delete();
      m_cur = '0;
      m_waited = 0;
      m_rsp_data = '0;
      m_rsp_hit = 1'b0;
      m_rsp_wr = 1'b0;
      m_req_cnt = '0;
      m_hit_cnt = '0;
    end else begin
      do_push = cmd_valid && (m_q.size() < 4);
      case (m_phase)
        P_WAIT_CMD: begin
          if (m_q.size() > 0) begin
            head = m_q.pop_front();
            if (head.addr[0]) m_phase = P_FAULT;
            else begin
              m_cur = head;
              m_waited = 0;
              m_phase = P_MEM_BUSY;
            end
          end
        end
        P_MEM_BUSY: begin
          if (mem_err) m_phase = P_FAULT;
          else if (Done) begin
            m_rsp_data = m_cur.wr ? 16'h0000 : DataOut;
            m_rsp_hit = CacheHit;
            m_rsp_wr = m_cur.wr;
            m_phase = P_REPLY;
          end else begin
            m_waited++;
            if (m_waited >= 63) m_phase = P_FAULT;
          end
        end
        P_REPLY: begin
          m_req_cnt = m_req_cnt + 16'd1;
          if (m_rsp_hit) m_hit_cnt = m_hit_cnt + 16'd1;
          m_phase = P_WAIT_CMD;
        end
        default: ;
      endcase
      if (do_push) m_q.push_back({cmd_wr, cmd_addr, cmd_data});
    end
  end

  always @(negedge clk) begin : compare
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_q.size() < 4});
    chk("Rd", {31'd0, Rd}, {31'd0, (m_phase == P_MEM_BUSY) && !m_cur.wr});
    chk("Wr", {31'd0, Wr}, {31'd0, (m_phase == P_MEM_BUSY) && m_cur.wr});
    chk("Addr", {16'd0, Addr}, {16'd0, m_cur.addr});
    chk("DataIn", {16'd0, DataIn}, {16'd0, m_cur.data});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == P_REPLY});
    if (m_phase == P_REPLY) begin
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, m_rsp_data});
      chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, m_rsp_hit});
      chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, m_rsp_wr});
    end
    chk("req_cnt", {16'd0, req_cnt}, {16'd0, m_req_cnt});
    chk("hit_cnt", {16'd0, hit_cnt}, {16'd0, m_hit_cnt});
    chk("err", {31'd0, err}, {31'd0, m_phase == P_FAULT});
    chk("createdump", {31'd0, createdump}, 32'd0);
    if (Rd) rd_cyc++;
    if (Wr) wr_cyc++;
    if (rsp_valid) rsp_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic wr, input logic [15:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_wr = wr;
    cmd_addr = a;
    cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait for the request to appear, hold off d cycles, then pulse Done for one cycle.
  task automatic serve(input int d, input logic [15:0] dat, input logic hit, input logic merr);
    int t = 0;
    while (!(Rd || Wr) && t < 200) begin
      tick();
      t++;
    end
    chk("serve_request_seen", {31'd0, Rd || Wr}, 32'd1);
    if (Rd || Wr) begin
      repeat (d) tick();
      Done = 1'b1;
      DataOut = dat;
      CacheHit = hit;
      mem_err = merr;
      tick();
      Done = 1'b0;
      DataOut = 16'h0000;
      CacheHit = 1'b0;
      mem_err = 1'b0;
    end
  endtask

  int snap_rd, snap_wr, snap_rsp;

  initial begin : stim
    cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_data = 0;
    DataOut = 0; Done = 0; Stall = 0; CacheHit = 0; mem_err = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_Rd", {31'd0, Rd}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_req_cnt", {16'd0, req_cnt}, 32'd0);
    chk("rst_Addr", {16'd0, Addr}, 32'd0);
    tick();
    rst = 1'b0;

    // Scenario 1: single load, hit on the first request cycle
    snap_rd = rd_cyc;
    push(1'b0, 16'h0010, 16'h0000);
    serve(0, 16'hBEEF, 1'b1, 1'b0);
    chk("s1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("s1_rsp_data", {16'd0, rsp_data}, 32'h0000BEEF);
    chk("s1_rsp_hit", {31'd0, rsp_hit}, 32'd1);
    tick();
    chk("s1_req_cnt", {16'd0, req_cnt}, 32'd1);
    chk("s1_hit_cnt", {16'd0, hit_cnt}, 32'd1);
    chk("s1_rd_cycles", rd_cyc - snap_rd, 32'd1);

    // Scenario 2: stalled store completing after 10 extra cycles
    reset_dut();
    Stall = 1'b1;
    snap_wr = wr_cyc;
    push(1'b1, 16'h0020, 16'h1234);
    serve(10, 16'hFFFF, 1'b0, 1'b0);
    Stall = 1'b0;
    chk("s2_rsp_wr", {31'd0, rsp_wr}, 32'd1);
    chk("s2_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    chk("s2_rsp_data", {16'd0, rsp_data}, 32'd0);
    tick();
    chk("s2_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("s2_wr_cycles", wr_cyc - snap_wr, 32'd11);
    chk("s2_Addr_hold", {16'd0, Addr}, 32'h00000020);

    // Scenario 3: five back-to-back commands fill the queue, then drain in order
    reset_dut();
    snap_rsp = rsp_seen;
    for (int i = 0; i < 5; i++) push(i == 1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
    chk("s3_full", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 5; i++) serve(0, 16'(16'hC000 + i), (i % 2) == 1, 1'b0);
    tick();
    tick();
    chk("s3_rsp_count", rsp_seen - snap_rsp, 32'd5);
    chk("s3_req_cnt", {16'd0, req_cnt}, 32'd5);
    chk("s3_hit_cnt", {16'd0, hit_cnt}, 32'd2);

    // Scenario 6: async reset in the middle of a request (counters non-zero beforehand)
    for (int i = 0; i < 5; i++) push(1'b0, 16'(16'h0300 + 2 * i), 16'h0000);
    chk("s6_Rd_before", {31'd0, Rd}, 32'd1);
    chk("s6_full_before", {31'd0, cmd_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("s6_Rd", {31'd0, Rd}, 32'd0);
    chk("s6_err", {31'd0, err}, 32'd0);
    chk("s6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("s6_req_cnt", {16'd0, req_cnt}, 32'd0);
    chk("s6_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("s6_Addr", {16'd0, Addr}, 32'd0);
    tick();
    rst = 1'b0;

    // Scenario 4: misaligned load goes straight to the error state
    snap_rd = rd_cyc;
    snap_wr = wr_cyc;
    push(1'b0, 16'h0003, 16'h0000);
    repeat (3) tick();
    chk("s4_err", {31'd0, err}, 32'd1);
    for (int i = 0; i < 4; i++) push(1'b0, 16'(16'h0200 + 2 * i), 16'h0000);
    chk("s4_full", {31'd0, cmd_ready}, 32'd0);
    push(1'b0, 16'h0208, 16'h0000);
    repeat (5) tick();
    chk("s4_rd_cycles", rd_cyc - snap_rd, 32'd0);
    chk("s4_wr_cycles", wr_cyc - snap_wr, 32'd0);
    chk("s4_req_cnt", {16'd0, req_cnt}, 32'd0);

    // Scenario 5: load never completes -> timeout after 63 request cycles
    reset_dut();
    snap_rd = rd_cyc;
    push(1'b0, 16'h0040, 16'h0000);
    repeat (70) tick();
    chk("s5_err", {31'd0, err}, 32'd1);
    chk("s5_rd_cycles", rd_cyc - snap_rd, 32'd63);
    snap_rsp = rsp_seen;
    Done = 1'b1;
    DataOut = 16'h1234;
    tick();
    Done = 1'b0;
    DataOut = 16'h0000;
    repeat (2) tick();
    chk("s5_late_done", rsp_seen - snap_rsp, 32'd0);
    chk("s5_req_cnt", {16'd0, req_cnt}, 32'd0);

    // Done on the 63rd request cycle still completes normally
    reset_dut();
    push(1'b0, 16'h0042, 16'h0000);
    serve(62, 16'h5A5A, 1'b0, 1'b0);
    chk("s5b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("s5b_rsp_data", {16'd0, rsp_data}, 32'h00005A5A);
    chk("s5b_err", {31'd0, err}, 32'd0);

    // mem_err together with Done: error wins, no response
    reset_dut();
    snap_rsp = rsp_seen;
    push(1'b0, 16'h0044, 16'h0000);
    serve(0, 16'h7777, 1'b1, 1'b1);
    chk("s7_err", {31'd0, err}, 32'd1);
    tick();
    chk("s7_no_rsp", rsp_seen - snap_rsp, 32'd0);
    chk("s7_req_cnt", {16'd0, req_cnt}, 32'd0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
